ins_loader: RTL and testbench
=============================

INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 Parameter INS_ADDR_WIDTH, default 10, SHALL set the instruction memory address width.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the width of each operand/result address field.
REQ-003 Parameter OPCODE_WIDTH, default 3, SHALL set the opcode field width; instruction width IW = OPCODE_WIDTH+3*ADDR_WIDTH (33 at defaults).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse that begins a load session.
REQ-007 num_ins  in  INS_ADDR_WIDTH+1  instruction count, sampled on an accepted start.
REQ-008 abort  in  1  synchronous session cancel.
REQ-009 s_data  in  8  instruction byte stream.
REQ-010 s_valid  in  1  s_data valid.
REQ-011 s_ready  out  1  loader accepts a byte this cycle.
REQ-012 ins_we  out  1  instruction memory write enable.
REQ-013 ins_addr  out  INS_ADDR_WIDTH  instruction memory write address.
REQ-014 ins_wdata  out  IW  instruction word.
REQ-015 busy  out  1  session in progress.
REQ-016 done  out  1  one-cycle session-complete pulse.
REQ-017 err_illegal  out  1  sticky illegal-instruction flag.

Function
REQ-018 FSM states SHALL be IDLE, RECV, WRITE, DONE.
REQ-019 IDLE: start=1 SHALL latch num_ins, clear the write address counter to 0, clear err_illegal, and go to RECV; if num_ins=0, go to DONE instead.
REQ-020 start SHALL be ignored in any state other than IDLE.
REQ-021 Each instruction SHALL arrive as 5 bytes, MSB first; the 40-bit assembled word W has ins_wdata = W[IW-1:0] and pad bits W[39:IW].
REQ-022 s_ready SHALL be 1 only in RECV; a byte is accepted only when s_valid && s_ready.
REQ-023 RECV SHALL shift accepted bytes into W and count them 0..4; the 5th acceptance SHALL go to WRITE with the byte counter reset to 0.
REQ-024 WRITE SHALL last exactly one cycle with ins_we=1, ins_addr=current counter, ins_wdata=W[IW-1:0], s_ready=0.
REQ-025 Latency: ins_we SHALL assert the cycle after the 5th byte handshake.
REQ-026 After WRITE the address counter SHALL increment (mod 2^INS_ADDR_WIDTH); if instructions written = latched num_ins, go to DONE, else RECV.
REQ-027 num_ins above 2^INS_ADDR_WIDTH SHALL saturate to 2^INS_ADDR_WIDTH; the address SHALL never wrap within a session.
REQ-028 Illegal instruction = opcode field W[IW-1 -: OPCODE_WIDTH] > 3'b101, or any nonzero pad bit; it SHALL still be written as received and SHALL set err_illegal in the WRITE cycle.
REQ-029 err_illegal SHALL hold until the next accepted start or reset.
REQ-030 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-031 busy SHALL be 1 in RECV and WRITE, 0 in IDLE and DONE.
REQ-032 abort=1 in any state SHALL go to IDLE next cycle, discard partial bytes, suppress ins_we and done that cycle; abort has priority over start and handshakes.
REQ-033 ins_we, done, s_ready SHALL be registered-state decodes, free of combinational paths from inputs.

Reset
REQ-034 rstn=0 SHALL asynchronously force IDLE, byte and address counters 0, W=0, ins_we=0, ins_addr=0, ins_wdata=0, s_ready=0, busy=0, done=0, err_illegal=0.
REQ-035 Reset deassertion mid-session SHALL leave the block in IDLE awaiting start; no memory write SHALL follow.

Verification
REQ-036 start, num_ins=1; bytes 00 00 10 08 03 -> one ins_we at ins_addr 0, ins_wdata 0x000100803 (ADD a=1 b=2 r=3); done pulse next cycle; err_illegal=0.
REQ-037 num_ins=2; bytes 00 00 10 08 03, 00 80 40 14 06 with s_valid gaps -> writes addr 0 = 0x000100803, addr 1 = 0x080401406; s_ready=0 in each WRITE cycle.
REQ-038 num_ins=1; bytes 01 C0 00 00 00 (opcode 7) -> write 0x1C0000000 at addr 0, err_illegal=1 until next start; bytes 02 00 00 00 00 (pad set) -> err_illegal=1.
REQ-039 num_ins=0 -> done one cycle after start, no ins_we, busy stays 0.
REQ-040 abort after 3 bytes, then new start num_ins=1 with 5 fresh bytes -> only fresh word written at addr 0; same check with rstn pulsed low mid-word.
REQ-041 start asserted while busy -> ignored; num_ins=1024 -> last write at addr 1023, then done.

Source files
------------

// File: rtl/ins_loader.sv
// ins_loader: assembles 5-byte instructions from a byte stream and writes them
// into instruction memory. It flags illegal opcodes and nonzero pad bits.
module ins_loader #(
   parameter int INS_ADDR_WIDTH = 10,
   parameter int ADDR_WIDTH     = 10,
   parameter int OPCODE_WIDTH   = 3
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic                                   start,
   input  logic [INS_ADDR_WIDTH:0]                num_ins,
   input  logic                                   abort,
   input  logic [7:0]                             s_data,
   input  logic                                   s_valid,
   output logic                                   s_ready,
   output logic                                   ins_we,
   output logic [INS_ADDR_WIDTH-1:0]              ins_addr,
   output logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0]   ins_wdata,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   err_illegal
);

   localparam int IW = OPCODE_WIDTH + 3*ADDR_WIDTH;
   // Bits of the 40-bit assembled word that sit above the instruction field.
   localparam logic [39:0] PAD_MASK = ~((40'd1 << IW) - 40'd1);
   // Largest session length: one full pass over the address space.
   localparam logic [INS_ADDR_WIDTH:0] MAX_INS = {1'b1, {INS_ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   state_t                      state_q, state_d;
   logic [2:0]                  bcnt_q, bcnt_d;
   logic [INS_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [INS_ADDR_WIDTH:0]     cnt_q, cnt_d;
   logic [39:0]                 w_q, w_d;
   logic                        err_q, err_d;
   logic [INS_ADDR_WIDTH:0]     num_sat;
   logic [INS_ADDR_WIDTH:0]     written;

   // An instruction is illegal if its opcode is above 5 or any pad bit is set.
   function automatic logic is_illegal(input logic [39:0] w);
      return (w[IW-1 -: OPCODE_WIDTH] > OPCODE_WIDTH'(5)) || ((w & PAD_MASK) != 40'd0);
   endfunction

   assign num_sat = (num_ins > MAX_INS) ? MAX_INS : num_ins;
   // Count of words written including the one being written in this WRITE cycle.
   assign written = {1'b0, addr_q} + {{INS_ADDR_WIDTH{1'b0}}, 1'b1};

   // Next-state, counters and word assembly; abort overrides everything.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      err_d   = err_q;
      if (abort) begin
         state_d = IDLE;
         bcnt_d  = 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  cnt_d   = num_sat;
                  addr_d  = '0;
                  bcnt_d  = 3'd0;
                  err_d   = 1'b0;
                  state_d = (num_sat == '0) ? DONE : RECV;
               end
            end
            RECV: begin
               if (s_valid) begin
                  w_d = {w_q[31:0], s_data};
                  if (bcnt_q == 3'd4) begin
                     bcnt_d  = 3'd0;
                     state_d = WRITE;
                  end else begin
                     bcnt_d = bcnt_q + 3'd1;
                  end
               end
            end
            WRITE: begin
               if (is_illegal(w_q)) begin
                  err_d = 1'b1;
               end
               addr_d  = addr_q + {{(INS_ADDR_WIDTH-1){1'b0}}, 1'b1};
               state_d = (written == cnt_q) ? DONE : RECV;
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         bcnt_q  <= 3'd0;
         addr_q  <= '0;
         cnt_q   <= '0;
         w_q     <= 40'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         err_q   <= err_d;
      end
   end

   // Handshake and status outputs decode registered state only.
   assign s_ready     = (state_q == RECV);
   assign ins_we      = (state_q == WRITE);
   assign done        = (state_q == DONE);
   assign busy        = (state_q == RECV) || (state_q == WRITE);
   assign ins_addr    = addr_q;
   assign ins_wdata   = w_q[IW-1:0];
   assign err_illegal = err_q;

endmodule

// File: tb/tb_ins_loader.sv
// Scoreboard bench for ins_loader: the driver pushes expected writes and done
// events; a monitor pops and compares whenever the DUT writes or completes.
module tb_ins_loader;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [10:0] num_ins = '0;
   logic        abort = 1'b0;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        ins_we;
   logic [9:0]  ins_addr;
   logic [32:0] ins_wdata;
   logic        busy;
   logic        done;
   logic        err_illegal;

   ins_loader dut (
      .clk(clk), .rstn(rstn), .start(start), .num_ins(num_ins), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ins_we(ins_we),
      .ins_addr(ins_addr), .ins_wdata(ins_wdata), .busy(busy), .done(done),
      .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   typedef struct { logic [9:0] addr; logic [32:0] data; bit err; } wr_t;
   typedef struct { bit err; int nwr; } dn_t;

   wr_t         wq[$];
   dn_t         dq[$];
   int          hs_q[$];
   logic [39:0] wlist[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_we = 0;
   int          gap_max = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Reference rule: opcode (bits 32..30) above 5 or any of bits 39..33 set.
   function automatic bit ref_illegal(input logic [39:0] w);
      return (((w >> 30) & 40'h7) > 40'd5) || ((w >> 33) != 40'd0);
   endfunction

   function automatic logic [39:0] rand_word(input int kind);
      logic [39:0] w;
      w = {7'd0, 3'($urandom_range(0, 5)), 10'($urandom), 10'($urandom), 10'($urandom)};
      if (kind == 1) w[32:30] = 3'($urandom_range(6, 7));
      if (kind == 2) w[39:33] = 7'($urandom_range(1, 127));
      return w;
   endfunction

   // Monitor: every write and every done pulse must match the scoreboard head.
   always @(negedge clk) begin
      if (rstn) begin
         if (ins_we) begin
            if (wq.size() == 0) begin
               timeout("unexpected_write");
            end else begin
               wr_t e;
               e = wq.pop_front();
               chk("ins_addr", 64'(ins_addr), 64'(e.addr));
               chk("ins_wdata", 64'(ins_wdata), 64'(e.data));
               chk("err_in_write", 64'(err_illegal), 64'(e.err));
               chk("s_ready_in_write", 64'(s_ready), 64'd0);
               chk("busy_in_write", 64'(busy), 64'd1);
               if (hs_q.size() != 0) chk("we_latency", 64'(cyc), 64'(hs_q.pop_front() + 1));
               last_we = cyc;
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               timeout("unexpected_done");
            end else begin
               dn_t d;
               d = dq.pop_front();
               chk("err_at_done", 64'(err_illegal), 64'(d.err));
               chk("busy_at_done", 64'(busy), 64'd0);
               if (d.nwr > 0) chk("done_after_last_we", 64'(cyc), 64'(last_we + 1));
            end
         end
      end
   end

   task automatic do_start(input int n);
      num_ins = 11'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last);
      int t;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      s_valid = 1'b1;
      s_data = b;
      t = 0;
      while (!s_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         timeout("byte_accept");
         s_valid = 1'b0;
         return;
      end
      if (last) hs_q.push_back(cyc);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((dq.size() != 0 || wq.size() != 0) && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (dq.size() != 0 || wq.size() != 0) begin
         timeout("session_complete");
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         wq.delete();
         dq.delete();
         hs_q.delete();
      end
      @(negedge clk);
   endtask

   // Model a full session over wlist, then drive it; inj pokes start while busy.
   task automatic session(input int n_req, input bit inj);
      int  n_eff;
      bit  sticky;
      n_eff = (n_req > 1024) ? 1024 : n_req;
      sticky = 1'b0;
      for (int i = 0; i < n_eff; i++) begin
         wr_t e;
         e.addr = 10'(i);
         e.data = wlist[i][32:0];
         e.err = sticky;
         wq.push_back(e);
         sticky = sticky | ref_illegal(wlist[i]);
      end
      dq.push_back('{err: sticky, nwr: n_eff});
      do_start(n_req);
      if (n_eff == 0) begin
         chk("zero_done_next_cycle", 64'(done), 64'd1);
         chk("zero_busy", 64'(busy), 64'd0);
      end
      for (int i = 0; i < n_eff; i++) begin
         for (int k = 0; k < 5; k++) begin
            send_byte(wlist[i][39 - 8*k -: 8], k == 4);
            if (inj && i == 0 && k == 2) begin
               num_ins = 11'd0;
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
               num_ins = 11'(n_req);
               chk("busy_after_start_while_busy", 64'(busy), 64'd1);
            end
         end
      end
      wait_idle();
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_ins_we", 64'(ins_we), 64'd0);
      chk("rst_ins_addr", 64'(ins_addr), 64'd0);
      chk("rst_ins_wdata", 64'(ins_wdata), 64'd0);
      chk("rst_busy_done_err", 64'({busy, done, err_illegal}), 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      // Single ADD instruction
      wlist = '{40'h0000100803};
      session(1, 1'b0);
      chk("err_after_add", 64'(err_illegal), 64'd0);

      // Two words with s_valid gaps and a start injected while busy
      gap_max = 2;
      wlist = '{40'h0000100803, 40'h0080401406};
      session(2, 1'b1);

      // Illegal opcode, sticky until next start
      wlist = '{40'h01C0000000};
      session(1, 1'b0);
      repeat (3) @(negedge clk);
      chk("err_sticky", 64'(err_illegal), 64'd1);
      // Pad bit set
      wlist = '{40'h0200000000};
      session(1, 1'b0);
      chk("err_pad", 64'(err_illegal), 64'd1);

      // Zero-length session
      session(0, 1'b0);
      chk("err_cleared_by_start", 64'(err_illegal), 64'd0);

      // Abort after three bytes, then a fresh word
      do_start(1);
      for (int k = 0; k < 3; k++) send_byte(8'hA5 + 8'(k), 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_s_ready", 64'(s_ready), 64'd0);
      wlist = '{40'h0000C0A1F2};
      session(1, 1'b0);

      // Reset pulse mid-word, then a fresh word
      do_start(1);
      for (int k = 0; k < 2; k++) send_byte(8'h3C, 1'b0);
      #1 rstn = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_s_ready", 64'(s_ready), 64'd0);
      chk("midrst_wdata", 64'(ins_wdata), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("postrst_idle", 64'({busy, ins_we, done}), 64'd0);
      wlist = '{40'h0000100803};
      session(1, 1'b0);

      // Randomized sessions, some with illegal words
      for (int s = 0; s < 10; s++) begin
         int n;
         n = $urandom_range(1, 6);
         wlist.delete();
         for (int i = 0; i < n; i++)
            wlist.push_back(rand_word(($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0));
         session(n, 1'b0);
      end

      // Full address space, exact and saturated counts
      gap_max = 0;
      wlist.delete();
      for (int i = 0; i < 1024; i++) wlist.push_back(rand_word(0));
      session(1024, 1'b0);
      session(1500, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench exceeded time limit");
      $fatal(1);
   end

endmodule
